prv_trap_ctrl: RTL and testbench
================================

PRV_TRAP_CTRL -- requirements
Module: prv_trap_ctrl

Interface
REQ-001 SHALL have ports CLK in 1 (sole clock, rising edge) and RST in 1 (synchronous, active-high reset).
REQ-002 SHALL have inputs fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env_m, 1 bit each: pipeline exception flags.
REQ-003 SHALL have inputs timer_int, soft_int, ext_int, 1 bit each: level-sensitive machine interrupt lines.
REQ-004 SHALL have inputs pipe_clear (1, pipeline drained), ret (1, mret in commit stage), curr_epc (32, PC of faulting instr) and curr_epc_p4 (32, PC+4 of retiring instr).
REQ-005 SHALL have inputs mtvec (32, trap base), mie_en (3, enables {ext,soft,timer}), mie_wen (1) and mie_wdata (1): CSR-file write to mstatus.MIE.
REQ-006 SHALL have outputs npc (32, redirect target), insert_pc (1, redirect strobe) and intr (1, trap/ret pending, flush request).
REQ-007 SHALL have outputs mepc (32), mcause (32), mstatus_mie (1) and mstatus_mpie (1) for CSR readback.

Function
REQ-008 SHALL implement FSM IDLE, WAIT_CLEAR, INSERT.
REQ-009 IDLE: a trap event (any exception flag, or any interrupt with its enable set and mstatus_mie=1) or ret SHALL latch kind, cause, epc and target, then move to WAIT_CLEAR next cycle.
REQ-010 WAIT_CLEAR: pipe_clear=1 SHALL move to INSERT; otherwise stay. New events are ignored; the latched values are held.
REQ-011 INSERT: insert_pc=1 and npc=latched target for exactly one cycle; SHALL then return to IDLE unconditionally.
REQ-012 intr SHALL be 1 in WAIT_CLEAR and INSERT, and combinationally 1 in IDLE the cycle an event is detected; 0 otherwise.
REQ-013 Exception priority, high to low (cause code): mal_insn(0), fault_insn(1), illegal_insn(2), breakpoint(3), env_m(11), mal_l(4), fault_l(5), mal_s(6), fault_s(7).
REQ-014 Interrupt priority: ext(11), soft(3), timer(7); mcause[31]=1 for interrupts and 0 for exceptions, code zero-extended in [30:0].
REQ-015 Simultaneous events: exception beats interrupt; trap beats ret.
REQ-016 Trap target SHALL be {mtvec[31:2],2'b00} (direct mode only); ret target SHALL be the current mepc.
REQ-017 Latched epc: curr_epc for exceptions, curr_epc_p4 for interrupts.
REQ-018 On the cycle entering INSERT, a trap SHALL update mepc<=epc, mcause<=cause, mstatus_mpie<=mstatus_mie, mstatus_mie<=0.
REQ-019 On the cycle entering INSERT, a ret SHALL update mstatus_mie<=mstatus_mpie, mstatus_mpie<=1; mepc and mcause are unchanged.
REQ-020 mie_wen=1 SHALL write mstatus_mie<=mie_wdata, except on a REQ-018/019 update cycle, where the FSM update wins.
REQ-021 npc SHALL hold its last driven value when insert_pc=0.

Reset
REQ-022 RST=1 SHALL force state=IDLE and npc, mepc, mcause=0; insert_pc, intr, mstatus_mie, mstatus_mpie=0.
REQ-023 RST asserted in WAIT_CLEAR or INSERT SHALL abort with no insert_pc pulse and no CSR update.

Structure
REQ-024 Exception and interrupt cause-code enums SHALL live in machine_mode_types_pkg; the FSM state enum stays local.
REQ-025 Priority selection SHALL be a sub-module prv_cause_encoder (flags in -> valid, is_int, 31-bit code out, purely combinational).
REQ-026 Target RTL size is 120-400 lines.

Verification
REQ-027 illegal_insn=1 with curr_epc=0x100, mtvec=0x8000_0001, mstatus_mie=1, pipe_clear high 2 cycles later -> one-cycle insert_pc, npc=0x8000_0000, mepc=0x100, mcause=2, mie=0, mpie=1.
REQ-028 mal_l=1 and timer_int=1 together, mie_en=3'b001, mstatus_mie=1 -> mcause=4 (exception wins).
REQ-029 ext_int=1 and soft_int=1, mie_en=3'b111, mstatus_mie=1, curr_epc_p4=0x204 -> mcause=0x8000_000B, mepc=0x204.
REQ-030 ret=1 with mepc=0x300, mpie=1, mie=0 -> npc=0x300, mie=1, mpie=1, mcause unchanged.
REQ-031 timer_int=1, mstatus_mie=0 -> intr=0, no insert_pc; then mie_wen=1, mie_wdata=1 -> trap taken, mcause=0x8000_0007.
REQ-032 RST=1 during WAIT_CLEAR -> IDLE next cycle, no insert_pc pulse, all outputs 0.

Source files
------------

// File: rtl/machine_mode_types_pkg.sv
// rtl/machine_mode_types_pkg.sv - machine-mode trap cause codes shared by the trap controller
package machine_mode_types_pkg;

    typedef enum logic [4:0] {
        EXC_INSN_MAL    = 5'd0,
        EXC_INSN_FAULT  = 5'd1,
        EXC_ILLEGAL     = 5'd2,
        EXC_BREAKPOINT  = 5'd3,
        EXC_LOAD_MAL    = 5'd4,
        EXC_LOAD_FAULT  = 5'd5,
        EXC_STORE_MAL   = 5'd6,
        EXC_STORE_FAULT = 5'd7,
        EXC_ECALL_M     = 5'd11
    } exc_cause_e;

    typedef enum logic [4:0] {
        INT_M_SOFT  = 5'd3,
        INT_M_TIMER = 5'd7,
        INT_M_EXT   = 5'd11
    } int_cause_e;

    function automatic logic [30:0] cause_code(input logic [4:0] c);
        return {26'd0, c};
    endfunction

endpackage

// File: rtl/prv_cause_encoder.sv
// rtl/prv_cause_encoder.sv - fixed-priority selection of the winning trap cause
module prv_cause_encoder
    import machine_mode_types_pkg::*;
(
    input  logic        mal_insn_i,
    input  logic        fault_insn_i,
    input  logic        illegal_insn_i,
    input  logic        breakpoint_i,
    input  logic        env_m_i,
    input  logic        mal_l_i,
    input  logic        fault_l_i,
    input  logic        mal_s_i,
    input  logic        fault_s_i,
    input  logic [2:0]  int_pend_i,
    output logic        valid_o,
    output logic        is_int_o,
    output logic [30:0] code_o
);

    logic [4:0] code_sel;

    // Interrupt lines arrive already masked; any exception outranks them.
    always_comb begin
        valid_o  = 1'b1;
        is_int_o = 1'b0;
        code_sel = 5'd0;
        if (mal_insn_i)          code_sel = EXC_INSN_MAL;
        else if (fault_insn_i)   code_sel = EXC_INSN_FAULT;
        else if (illegal_insn_i) code_sel = EXC_ILLEGAL;
        else if (breakpoint_i)   code_sel = EXC_BREAKPOINT;
        else if (env_m_i)        code_sel = EXC_ECALL_M;
        else if (mal_l_i)        code_sel = EXC_LOAD_MAL;
        else if (fault_l_i)      code_sel = EXC_LOAD_FAULT;
        else if (mal_s_i)        code_sel = EXC_STORE_MAL;
        else if (fault_s_i)      code_sel = EXC_STORE_FAULT;
        else begin
            is_int_o = 1'b1;
            if (int_pend_i[2])      code_sel = INT_M_EXT;
            else if (int_pend_i[1]) code_sel = INT_M_SOFT;
            else if (int_pend_i[0]) code_sel = INT_M_TIMER;
            else begin
                valid_o  = 1'b0;
                is_int_o = 1'b0;
            end
        end
        code_o = cause_code(code_sel);
    end

endmodule

// File: rtl/prv_trap_ctrl.sv
// rtl/prv_trap_ctrl.sv - machine-mode trap/mret sequencer with pipeline drain and PC redirect
module prv_trap_ctrl
    import machine_mode_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        fault_insn,
    input  logic        mal_insn,
    input  logic        illegal_insn,
    input  logic        fault_l,
    input  logic        mal_l,
    input  logic        fault_s,
    input  logic        mal_s,
    input  logic        breakpoint,
    input  logic        env_m,
    input  logic        timer_int,
    input  logic        soft_int,
    input  logic        ext_int,
    input  logic        pipe_clear,
    input  logic        ret,
    input  logic [31:0] curr_epc,
    input  logic [31:0] curr_epc_p4,
    input  logic [31:0] mtvec,
    input  logic [2:0]  mie_en,
    input  logic        mie_wen,
    input  logic        mie_wdata,
    output logic [31:0] npc,
    output logic        insert_pc,
    output logic        intr,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic        mstatus_mie,
    output logic        mstatus_mpie
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_CLEAR, S_INSERT} state_e;

    state_e      state_q, state_d;
    logic        is_ret_q, is_ret_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] npc_q, mepc_q, mcause_q;
    logic        mie_q, mpie_q;
    logic        event_now, commit;

    logic        enc_valid, enc_is_int;
    logic [30:0] enc_code;
    logic [2:0]  int_pend;
    logic        unused_mtvec_mode;

    assign unused_mtvec_mode = ^mtvec[1:0];
    assign int_pend = {ext_int, soft_int, timer_int} & mie_en & {3{mie_q}};

    prv_cause_encoder u_enc (
        .mal_insn_i     (mal_insn),
        .fault_insn_i   (fault_insn),
        .illegal_insn_i (illegal_insn),
        .breakpoint_i   (breakpoint),
        .env_m_i        (env_m),
        .mal_l_i        (mal_l),
        .fault_l_i      (fault_l),
        .mal_s_i        (mal_s),
        .fault_s_i      (fault_s),
        .int_pend_i     (int_pend),
        .valid_o        (enc_valid),
        .is_int_o       (enc_is_int),
        .code_o         (enc_code)
    );

    always_comb begin
        state_d   = state_q;
        is_ret_d  = is_ret_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        target_d  = target_q;
        event_now = 1'b0;
        commit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enc_valid || ret) begin
                    event_now = 1'b1;
                    state_d   = S_WAIT_CLEAR;
                    if (enc_valid) begin
                        is_ret_d = 1'b0;
                        cause_d  = {enc_is_int, enc_code};
                        epc_d    = enc_is_int ? curr_epc_p4 : curr_epc;
                        target_d = {mtvec[31:2], 2'b00};
                    end else begin
                        is_ret_d = 1'b1;
                        target_d = mepc_q;
                    end
                end
            end
            S_WAIT_CLEAR: begin
                if (pipe_clear) begin
                    state_d = S_INSERT;
                    commit  = 1'b1;
                end
            end
            S_INSERT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            is_ret_q <= 1'b0;
            cause_q  <= '0;
            epc_q    <= '0;
            target_q <= '0;
            npc_q    <= '0;
            mepc_q   <= '0;
            mcause_q <= '0;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_ret_q <= is_ret_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            target_q <= target_d;
            // CSR side effects land on the edge that enters INSERT and override software writes.
            if (commit) begin
                npc_q <= target_q;
                if (is_ret_q) begin
                    mie_q  <= mpie_q;
                    mpie_q <= 1'b1;
                end else begin
                    mepc_q   <= epc_q;
                    mcause_q <= cause_q;
                    mpie_q   <= mie_q;
                    mie_q    <= 1'b0;
                end
            end else if (mie_wen) begin
                mie_q <= mie_wdata;
            end
        end
    end

    // Gated by RST so an abort in INSERT never emits a redirect pulse.
    assign insert_pc    = !RST && (state_q == S_INSERT);
    assign intr         = !RST && ((state_q != S_IDLE) || event_now);
    assign npc          = npc_q;
    assign mepc         = mepc_q;
    assign mcause       = mcause_q;
    assign mstatus_mie  = mie_q;
    assign mstatus_mpie = mpie_q;

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// tb/tb_prv_trap_ctrl.sv - directed self-checking bench for prv_trap_ctrl
module tb_prv_trap_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s;
    logic        breakpoint, env_m, timer_int, soft_int, ext_int;
    logic        pipe_clear, ret;
    logic [31:0] curr_epc, curr_epc_p4, mtvec;
    logic [2:0]  mie_en;
    logic        mie_wen, mie_wdata;
    logic [31:0] npc, mepc, mcause;
    logic        insert_pc, intr, mstatus_mie, mstatus_mpie;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    prv_trap_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .fault_insn   (fault_insn),
        .mal_insn     (mal_insn),
        .illegal_insn (illegal_insn),
        .fault_l      (fault_l),
        .mal_l        (mal_l),
        .fault_s      (fault_s),
        .mal_s        (mal_s),
        .breakpoint   (breakpoint),
        .env_m        (env_m),
        .timer_int    (timer_int),
        .soft_int     (soft_int),
        .ext_int      (ext_int),
        .pipe_clear   (pipe_clear),
        .ret          (ret),
        .curr_epc     (curr_epc),
        .curr_epc_p4  (curr_epc_p4),
        .mtvec        (mtvec),
        .mie_en       (mie_en),
        .mie_wen      (mie_wen),
        .mie_wdata    (mie_wdata),
        .npc          (npc),
        .insert_pc    (insert_pc),
        .intr         (intr),
        .mepc         (mepc),
        .mcause       (mcause),
        .mstatus_mie  (mstatus_mie),
        .mstatus_mpie (mstatus_mpie)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_events();
        {fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s} = '0;
        {breakpoint, env_m, timer_int, soft_int, ext_int, ret} = '0;
    endtask

    task automatic set_mie();
        mie_wen = 1'b1; mie_wdata = 1'b1;
        tick();
        mie_wen = 1'b0; mie_wdata = 1'b0;
    endtask

    // Latch the pending event, drain for 'waits' cycles, then release pipe_clear; ends in INSERT.
    task automatic take(input int waits, input bit collide);
        tick();
        clear_events();
        for (int i = 0; i < waits; i++) begin
            check_eq("wait_insert_low", {31'd0, insert_pc}, 32'd0);
            tick();
        end
        pipe_clear = 1'b1;
        if (collide) begin
            mie_wen = 1'b1; mie_wdata = 1'b1;
        end
        tick();
        pipe_clear = 1'b0; mie_wen = 1'b0; mie_wdata = 1'b0;
        check_eq("insert_pulse", {31'd0, insert_pc}, 32'd1);
    endtask

    task automatic back_to_idle();
        tick();
        check_eq("insert_one_cycle", {31'd0, insert_pc}, 32'd0);
        check_eq("idle_intr", {31'd0, intr}, 32'd0);
    endtask

    initial begin
        RST = 1'b1;
        clear_events();
        pipe_clear = 0; curr_epc = 0; curr_epc_p4 = 0; mtvec = 0;
        mie_en = 0; mie_wen = 0; mie_wdata = 0;
        tick(); tick();
        check_eq("rst_npc", npc, 0);
        check_eq("rst_mepc", mepc, 0);
        check_eq("rst_mcause", mcause, 0);
        check_eq("rst_flags", {28'd0, insert_pc, intr, mstatus_mie, mstatus_mpie}, 0);
        RST = 1'b0;
        tick();
        check_eq("idle_no_event", {31'd0, intr}, 0);

        // Illegal instruction, drained after two waiting cycles; a late breakpoint is ignored
        set_mie();
        check_eq("mie_write", {31'd0, mstatus_mie}, 1);
        mtvec = 32'h8000_0001; curr_epc = 32'h100; illegal_insn = 1'b1;
        #1 check_eq("intr_comb", {31'd0, intr}, 1);
        tick();
        clear_events();
        breakpoint = 1'b1;
        check_eq("wc_intr", {31'd0, intr}, 1);
        check_eq("wc_insert_low", {31'd0, insert_pc}, 0);
        tick();
        breakpoint = 1'b0;
        check_eq("wc_insert_low2", {31'd0, insert_pc}, 0);
        pipe_clear = 1'b1;
        tick();
        pipe_clear = 1'b0;
        check_eq("ill_insert", {31'd0, insert_pc}, 1);
        check_eq("ill_npc", npc, 32'h8000_0000);
        check_eq("ill_mepc", mepc, 32'h100);
        check_eq("ill_mcause", mcause, 2);
        check_eq("ill_mie", {31'd0, mstatus_mie}, 0);
        check_eq("ill_mpie", {31'd0, mstatus_mpie}, 1);
        back_to_idle();
        check_eq("npc_hold", npc, 32'h8000_0000);

        // Exception beats interrupt
        set_mie();
        mie_en = 3'b001; mal_l = 1'b1; timer_int = 1'b1; curr_epc = 32'h140; curr_epc_p4 = 32'h144;
        take(1, 1'b0);
        check_eq("exc_wins_cause", mcause, 4);
        check_eq("exc_wins_mepc", mepc, 32'h140);
        back_to_idle();

        // External beats soft; software MIE write on the commit edge loses
        set_mie();
        mtvec = 32'h0000_1003; mie_en = 3'b111; ext_int = 1'b1; soft_int = 1'b1;
        curr_epc = 32'h200; curr_epc_p4 = 32'h204;
        take(0, 1'b1);
        check_eq("ext_cause", mcause, 32'h8000_000B);
        check_eq("ext_mepc", mepc, 32'h204);
        check_eq("ext_npc", npc, 32'h0000_1000);
        check_eq("collide_mie", {31'd0, mstatus_mie}, 0);
        back_to_idle();

        // env_m beats fault_s; sets mepc=0x300 with mpie=1, mie=0
        set_mie();
        env_m = 1'b1; fault_s = 1'b1; curr_epc = 32'h300;
        take(0, 1'b0);
        check_eq("ecall_cause", mcause, 11);
        check_eq("ecall_mpie", {30'd0, mstatus_mie, mstatus_mpie}, 32'd1);
        back_to_idle();

        ret = 1'b1;
        take(2, 1'b0);
        check_eq("ret_npc", npc, 32'h300);
        check_eq("ret_mie_mpie", {30'd0, mstatus_mie, mstatus_mpie}, 32'd3);
        check_eq("ret_mcause", mcause, 11);
        check_eq("ret_mepc", mepc, 32'h300);
        back_to_idle();

        // Trap beats ret
        ret = 1'b1; fault_l = 1'b1; curr_epc = 32'h400;
        take(0, 1'b0);
        check_eq("trap_vs_ret_cause", mcause, 5);
        check_eq("trap_vs_ret_npc", npc, 32'h1000);
        check_eq("trap_vs_ret_mepc", mepc, 32'h400);
        back_to_idle();

        // Timer masked by mstatus.MIE until software enables it
        mie_en = 3'b001; timer_int = 1'b1; curr_epc_p4 = 32'h508;
        #1 check_eq("masked_intr", {31'd0, intr}, 0);
        tick();
        check_eq("masked_insert", {31'd0, insert_pc}, 0);
        check_eq("masked_intr2", {31'd0, intr}, 0);
        mie_wen = 1'b1; mie_wdata = 1'b1;
        tick();
        mie_wen = 1'b0; mie_wdata = 1'b0;
        check_eq("unmasked_intr", {31'd0, intr}, 1);
        take(0, 1'b0);
        check_eq("timer_cause", mcause, 32'h8000_0007);
        check_eq("timer_mepc", mepc, 32'h508);
        back_to_idle();

        // Reset abort in WAIT_CLEAR
        illegal_insn = 1'b1; curr_epc = 32'h600;
        tick();
        clear_events();
        check_eq("abort_wc_intr", {31'd0, intr}, 1);
        RST = 1'b1; pipe_clear = 1'b1;
        #1 check_eq("abort_rst_intr", {30'd0, intr, insert_pc}, 0);
        tick();
        check_eq("abort_outs", {28'd0, insert_pc, intr, mstatus_mie, mstatus_mpie}, 0);
        check_eq("abort_mepc", mepc, 0);
        check_eq("abort_mcause", mcause, 0);
        check_eq("abort_npc", npc, 0);
        RST = 1'b0; pipe_clear = 1'b0;
        tick();
        check_eq("abort_no_pulse", {30'd0, insert_pc, intr}, 0);
        tick();
        check_eq("abort_no_pulse2", {30'd0, insert_pc, intr}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
